// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path constants, trigger encodings and helpers
package uart_pkg;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_TIMEOUT_TICKS = 40;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_lvl_e;

  // Line-status register bit positions for the FIFO status
  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_FULL = 2;
  localparam int LSR_TRIG = 3;
  localparam int LSR_TMO  = 4;

  // Holding-register mode always interrupts on the first character
  function automatic int trig_threshold(trig_lvl_e lvl, logic fifo_en, int depth);
    int n;
    if (!fifo_en) return 1;
    case (lvl)
      TRIG_1:  n = 1;
      TRIG_4:  n = 4;
      TRIG_8:  n = 8;
      default: n = 14;
    endcase
    n = (depth * n) / 16;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and register-side signals of the receive FIFO
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 4
);
  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              bit_tick;
  logic              fifo_en;
  logic              flush;
  logic [1:0]        trig_lvl;
  logic              rd_en;
  logic              ovr_clr;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              trig_irq;
  logic              timeout_irq;

  modport master (
    output rx_done, rx_data, bit_tick, fifo_en, flush, trig_lvl, rd_en, ovr_clr,
    input  rd_data, empty, full, count, overrun, trig_irq, timeout_irq
  );

  modport slave (
    input  rx_done, rx_data, bit_tick, fifo_en, flush, trig_lvl, rd_en, ovr_clr,
    output rd_data, empty, full, count, overrun, trig_irq, timeout_irq
  );
endinterface

// File: rtl/rx_timeout_cnt.sv
// rtl/rx_timeout_cnt.sv - character-timeout counter with sticky interrupt
module rx_timeout_cnt
  import uart_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bit_tick_i,
  input  logic clear_i,
  input  logic active_i,
  output logic timeout_irq_o
);
  localparam int                CNT_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !active_i)
      cnt_d = '0;
    else if (bit_tick_i && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // A write only restarts the count (via active_i); the irq itself survives it
  always_comb begin
    irq_d = irq_q;
    if (clear_i)
      irq_d = 1'b0;
    else if (active_i && (cnt_d == CNT_MAX))
      irq_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign timeout_irq_o = irq_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with overrun, trigger and timeout status
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam logic [ADDR_W:0] CAP_FIFO = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CAP_HOLD = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              overrun_q, overrun_d;
  logic              trig_irq_q, trig_irq_d;
  logic              fifo_en_q;
  logic [ADDR_W:0]   cap;
  logic              full, empty, wr_acc, rd_acc, ovr_evt;
  logic              timeout_irq;

  // Mode is registered so full/empty depend only on flops
  always_comb begin
    cap     = fifo_en_q ? CAP_FIFO : CAP_HOLD;
    full    = (count_q == cap);
    empty   = (count_q == '0);
    rd_acc  = bus.rd_en && !empty && !bus.flush;
    wr_acc  = bus.rx_done && !bus.flush && (!full || rd_acc);
    ovr_evt = bus.rx_done && !bus.flush && full && !rd_acc;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (ovr_evt)
      overrun_d = 1'b1;
    else if (bus.ovr_clr)
      overrun_d = 1'b0;
    trig_irq_d = int'(count_d) >=
                 trig_threshold(trig_lvl_e'(bus.trig_lvl), fifo_en_q, DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overrun_q  <= 1'b0;
      trig_irq_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      overrun_q  <= overrun_d;
      trig_irq_q <= trig_irq_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_en_q <= bus.fifo_en;
    if (wr_acc) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  // Counting is suspended while empty or in a write cycle; read/flush also drop the irq
  rx_timeout_cnt #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .clk_i         (clk),
    .rst_i         (rst),
    .bit_tick_i    (bus.bit_tick),
    .clear_i       (rd_acc || bus.flush),
    .active_i      (!empty && !wr_acc),
    .timeout_irq_o (timeout_irq)
  );

  assign bus.rd_data     = rd_data_q;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.count       = count_q;
  assign bus.overrun     = overrun_q;
  assign bus.trig_irq    = trig_irq_q;
  assign bus.timeout_irq = timeout_irq;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for the UART receive FIFO
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_rx_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic       rd_seen = 1'b0;

  // Monitor: a read strobe seen at an edge produces rd_data by the next falling edge
  always @(posedge clk) rd_seen <= bus.rd_en && !rst;

  always @(negedge clk) begin
    if (rd_seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd_data !== exp_v) begin
        errors++;
        $display("FAIL rd_data: got %02h expected %02h at %0t", bus.rd_data, exp_v, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    bus.rx_done = 1'b1;
    bus.rx_data = d;
    tick();
    bus.rx_done = 1'b0;
  endtask

  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] e, input logic [7:0] d);
    exp_q.push_back(e);
    bus.rd_en   = 1'b1;
    bus.rx_done = 1'b1;
    bus.rx_data = d;
    tick();
    bus.rd_en   = 1'b0;
    bus.rx_done = 1'b0;
  endtask

  task automatic do_flush(input logic en);
    bus.fifo_en = en;
    bus.flush   = 1'b1;
    tick();
    bus.flush   = 1'b0;
  endtask

  initial begin
    bus.rx_done  = 1'b0;
    bus.rx_data  = '0;
    bus.bit_tick = 1'b0;
    bus.fifo_en  = 1'b1;
    bus.flush    = 1'b0;
    bus.trig_lvl = 2'b00;
    bus.rd_en    = 1'b0;
    bus.ovr_clr  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_trig", bus.trig_irq, 0);
    chk("rst_timeout", bus.timeout_irq, 0);

    // Basic three-character pass
    wr(8'h41); wr(8'h42); wr(8'h43);
    chk("t1_count", bus.count, 3);
    chk("t1_empty", bus.empty, 0);
    rd(8'h41); rd(8'h42); rd(8'h43);
    chk("t1_empty_after", bus.empty, 1);

    // Fill past capacity in FIFO mode
    for (int i = 0; i < 17; i++) begin
      wr(8'(i));
      if (i == 15) begin
        chk("t2_full16", bus.full, 1);
        chk("t2_no_ovr16", bus.overrun, 0);
      end
    end
    chk("t2_overrun17", bus.overrun, 1);
    chk("t2_count17", bus.count, 16);
    for (int i = 0; i < 16; i++) rd(8'(i));
    chk("t2_empty", bus.empty, 1);
    bus.ovr_clr = 1'b1; tick(); bus.ovr_clr = 1'b0;
    chk("t2_ovr_clr", bus.overrun, 0);

    // Holding-register mode
    do_flush(1'b0);
    wr(8'h55);
    wr(8'hAA);
    chk("t3_overrun", bus.overrun, 1);
    chk("t3_full", bus.full, 1);
    chk("t3_count", bus.count, 1);
    rd(8'h55);
    bus.ovr_clr = 1'b1; tick(); bus.ovr_clr = 1'b0;
    chk("t3_ovr_clr", bus.overrun, 0);
    wr(8'h11);
    chk("t3_trig_hold", bus.trig_irq, 1);
    bus.ovr_clr = 1'b1;
    wr(8'h22);
    bus.ovr_clr = 1'b0;
    chk("t3_set_wins", bus.overrun, 1);
    rd(8'h11);
    bus.ovr_clr = 1'b1; tick(); bus.ovr_clr = 1'b0;
    do_flush(1'b1);

    // Trigger level 8
    bus.trig_lvl = 2'b10;
    for (int i = 0; i < 7; i++) wr(8'h80 + 8'(i));
    chk("t4_trig7", bus.trig_irq, 0);
    wr(8'h87);
    chk("t4_trig8", bus.trig_irq, 1);
    chk("t4_count8", bus.count, 8);
    rd(8'h80);
    chk("t4_trig_rd", bus.trig_irq, 0);
    bus.trig_lvl = 2'b00;
    do_flush(1'b1);

    // Character timeout
    wr(8'h33);
    for (int i = 1; i <= 40; i++) begin
      bus.bit_tick = 1'b1;
      tick();
      bus.bit_tick = 1'b0;
      if (i == 39) chk("t5_tmo39", bus.timeout_irq, 0);
      if (i == 40) chk("t5_tmo40", bus.timeout_irq, 1);
      tick();
    end
    rd(8'h33);
    chk("t5_tmo_rd", bus.timeout_irq, 0);
    chk("t5_empty", bus.empty, 1);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    chk("t5_rd_empty_hold", bus.rd_data, 8'h33);
    chk("t5_rd_empty_cnt", bus.count, 0);

    // Wrap, overrun, then flush with concurrent write
    for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i));
    chk("t6_full", bus.full, 1);
    wr(8'hEE);
    chk("t6_overrun", bus.overrun, 1);
    for (int i = 0; i < 10; i++) rdwr(8'hC0 + 8'(i), 8'hD0 + 8'(i));
    chk("t6_count_rw", bus.count, 16);
    bus.flush   = 1'b1;
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h77;
    tick();
    bus.flush   = 1'b0;
    bus.rx_done = 1'b0;
    chk("t6_flush_count", bus.count, 0);
    chk("t6_flush_empty", bus.empty, 1);
    chk("t6_flush_ovr", bus.overrun, 1);
    wr(8'h5A);
    rd(8'h5A);
    chk("t6_final_empty", bus.empty, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    tick();
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer placed directly downstream of the UART receiver. It captures each completed character, presented as a one-clock rx_done pulse with rx_data, into a circular FIFO. It then hands characters to the register/bus side via a read strobe. It also generates line-status information: data-ready, overrun, a trigger-level interrupt and a character-timeout interrupt.

Parameters:
DATA_W, 8, character width (matches receiver rx_data)
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
TIMEOUT_TICKS, 40, bit_tick periods of inactivity before timeout_irq (4 chars x 10 bits)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_done  in  1  one-clk pulse: rx_data valid
rx_data  in  DATA_W  received character (already right-aligned by receiver)
bit_tick  in  1  one-clk pulse per bit period (from baud/tick generator)
fifo_en  in  1  1 = DEPTH-entry FIFO mode; 0 = single holding-register mode
flush  in  1  clear FIFO contents
trig_lvl  in  2  interrupt trigger level select
rd_en  in  1  pop one character
ovr_clr  in  1  clear sticky overrun
rd_data  out  DATA_W  popped character (registered)
empty  out  1  FIFO empty (data-ready = ~empty)
full  out  1  FIFO full
count  out  ADDR_W+1  occupancy 0..DEPTH
overrun  out  1  sticky overrun flag
trig_irq  out  1  occupancy >= trigger threshold
timeout_irq  out  1  character timeout

Behaviour:
- Reset, sync on rst=1 at clk edge: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_data=0, overrun=0, trig_irq=0, timeout_irq=0, timeout counter=0. Memory contents are not reset.
- Capacity: cap = DEPTH if fifo_en=1, else 1. full = (count==cap); empty = (count==0). All flags are derived from registered count.
- Write: rx_done=1 and not full -> mem[wr_ptr]<=rx_data, wr_ptr wraps mod DEPTH, count+1.
- Write while full: rx_done=1, full=1, rd_en=0 -> character dropped, pointers unchanged, overrun<=1.
- Read: rd_en=1 and not empty -> rd_data<=mem[rd_ptr] (valid the cycle after rd_en), rd_ptr wraps, count-1.
- Read while empty: no state change; rd_data holds its last value.
- Simultaneous read+write when full: both accepted, count stays at cap, no overrun.
- Simultaneous read+write when empty: write accepted, read ignored (no bypass); count becomes 1.
- Simultaneous read+write otherwise: both accepted, count unchanged.
- flush: highest priority. Pointers and count go to 0 that cycle; a same-cycle rx_done is discarded without setting overrun. Same-cycle rd_en is ignored. overrun is unaffected; timeout_irq and the timeout counter are cleared.
- fifo_en change: the block requires flush to accompany it. Toggling fifo_en without flush leaves the pointers intact, and full/empty follow the new cap.
- overrun: sticky until ovr_clr=1. If ovr_clr and a new overrun event fall in the same cycle, set wins.
- Trigger threshold, fifo_en=1: trig_lvl 00->1, 01->4, 10->8, 11->14. Thresholds are scaled DEPTH*n/16, with a minimum of 1.
- Trigger threshold, fifo_en=0: threshold is 1.
- trig_irq is registered and computed from the next-state count, so it asserts in the same cycle count reaches the threshold.
- Timeout counter: cleared on any accepted write, accepted read, flush, or while count==0. Otherwise it increments on bit_tick and saturates at TIMEOUT_TICKS.
- timeout_irq: set when the counter reaches TIMEOUT_TICKS with count!=0. Cleared by an accepted read, flush, or count reaching 0. A new write clears the counter but does not clear an already-set timeout_irq.
- No combinational path from any input to any output.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_W default
  - trig_lvl encodings TRIG_1/TRIG_4/TRIG_8/TRIG_14
  - default TIMEOUT_TICKS
  - FIFO status bit positions for the line-status register
- One sub-module: rx_timeout_cnt. It contains the counter and sticky timeout_irq logic, with inputs bit_tick, clear, active and output timeout_irq.
- Storage and pointer logic stay in the top module.

Test Plan:
- Reset, then 3 rx_done pulses with data 0x41, 0x42, 0x43 -> count=3, empty=0. Three rd_en pulses -> rd_data=0x41, 0x42, 0x43 (each one cycle after its rd_en), then empty=1.
- fifo_en=1: 17 writes 0x00..0x10 with no reads -> full=1 after the 16th write and overrun=1 after the 17th. Reading all 16 returns 0x00..0x0F (0x10 lost). ovr_clr -> overrun=0.
- fifo_en=0: two writes 0x55 then 0xAA -> overrun=1. A read returns 0x55. Same-cycle ovr_clr with a third write while full -> overrun stays 1.
- trig_lvl=10: 7 writes -> trig_irq=0. 8th write -> trig_irq=1 in the same cycle count=8. One read -> trig_irq=0.
- Write one char, then 40 bit_tick pulses with no activity -> timeout_irq=1 on the 40th. A read -> timeout_irq=0, empty=1.
- Fill 16 entries, wrap the pointers by interleaving 10 reads/10 writes, then flush concurrently with rx_done -> count=0, empty=1, overrun unchanged. A subsequent write/read round-trips 0x5A.
